// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W  = 32;
    localparam int WORD_W  = 32;
    localparam int FETCH_W = 64;
    localparam int STRB_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_D_ADDR  = 3'd1,
        ST_D_DATA  = 3'd2,
        ST_I_ADDR0 = 3'd3,
        ST_I_DATA0 = 3'd4,
        ST_I_ADDR1 = 3'd5,
        ST_I_DATA1 = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    function automatic logic is_addr_state(input state_t s);
        return (s == ST_D_ADDR) || (s == ST_I_ADDR0) || (s == ST_I_ADDR1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a two-word instruction fetch port and a load/store port onto one
// single-word memory port with one transfer outstanding at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               inst_req,
    input  logic [ADDR_W-1:0]  inst_addr,
    output logic               inst_done,
    output logic [FETCH_W-1:0] inst_rdata,
    input  logic               data_req,
    input  logic [STRB_W-1:0]  data_wen,
    input  logic [ADDR_W-1:0]  data_addr,
    input  logic [WORD_W-1:0]  data_wdata,
    output logic               data_done,
    output logic [WORD_W-1:0]  data_rdata,
    output logic               mem_req,
    output logic               mem_wr,
    output logic [STRB_W-1:0]  mem_wstrb,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_wdata,
    input  logic               mem_addr_ok,
    input  logic               mem_data_ok,
    input  logic [WORD_W-1:0]  mem_rdata,
    output state_t             dbg_state
);

    // Handshake: mem_req holds a stable address/write until mem_addr_ok, the
    // result returns on mem_data_ok; requesters hold their inputs until *_done.
    state_t              state, state_n;
    logic                last_data;
    logic                flush_pend;
    logic [ADDR_W-1:0]   lat_addr;
    logic [STRB_W-1:0]   lat_wen;
    logic [WORD_W-1:0]   lat_wdata;
    logic [WORD_W-1:0]   lo_word;
    logic                grant_inst, grant_data, fetch_active, addr_phase;

    assign dbg_state = state;

    always_comb begin
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        state_n      = state;
        fetch_active = 1'b0;
        addr_phase   = is_addr_state(state);
        if (state == ST_IDLE) begin
            // Inst wins only when data was served last, so neither side starves.
            grant_inst = inst_req && !flush && (!data_req || last_data);
            grant_data = data_req && !grant_inst;
        end
        case (state)
            ST_IDLE: begin
                if (grant_data)      state_n = ST_D_ADDR;
                else if (grant_inst) state_n = ST_I_ADDR0;
            end
            ST_D_ADDR:  if (mem_addr_ok) state_n = ST_D_DATA;
            ST_D_DATA:  if (mem_data_ok) state_n = ST_DONE;
            ST_I_ADDR0: if (mem_addr_ok) state_n = ST_I_DATA0;
            ST_I_DATA0: if (mem_data_ok) state_n = ST_I_ADDR1;
            ST_I_ADDR1: if (mem_addr_ok) state_n = ST_I_DATA1;
            ST_I_DATA1: if (mem_data_ok) state_n = ST_DONE;
            ST_DONE:    state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
        case (state)
            ST_I_ADDR0, ST_I_DATA0, ST_I_ADDR1, ST_I_DATA1: fetch_active = 1'b1;
            ST_DONE: fetch_active = !last_data;
            default: fetch_active = 1'b0;
        endcase

        mem_req   = addr_phase;
        mem_addr  = addr_phase ? lat_addr  : '0;
        mem_wstrb = addr_phase ? lat_wen   : '0;
        mem_wdata = addr_phase ? lat_wdata : '0;
        mem_wr    = addr_phase && (lat_wen != '0);
        data_done = (state == ST_DONE) && last_data;
        inst_done = (state == ST_DONE) && !last_data && !flush_pend && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_data  <= 1'b0;
            flush_pend <= 1'b0;
            lat_addr   <= '0;
            lat_wen    <= '0;
            lat_wdata  <= '0;
            lo_word    <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            state <= state_n;
            if (flush && fetch_active)
                flush_pend <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (grant_data) begin
                        lat_addr  <= data_addr;
                        lat_wen   <= data_wen;
                        lat_wdata <= data_wdata;
                        last_data <= 1'b1;
                    end else if (grant_inst) begin
                        lat_addr   <= inst_addr;
                        lat_wen    <= '0;
                        lat_wdata  <= '0;
                        last_data  <= 1'b0;
                        flush_pend <= 1'b0;
                    end
                end
                ST_D_DATA:
                    if (mem_data_ok) data_rdata <= mem_rdata;
                ST_I_DATA0: begin
                    if (mem_data_ok) begin
                        lo_word  <= mem_rdata;
                        lat_addr <= lat_addr + 32'd4;
                    end
                end
                ST_I_DATA1:
                    if (mem_data_ok) inst_rdata <= {mem_rdata, lo_word};
                default: ;
            endcase
        end
    end

endmodule
